// File: rtl/truth_table_checker.sv
// Truth-table sweep checker: steps through every input vector, holds it for a settle
// window, then compares the SumOfProducts output (and the KMap output when TT_KMAP_CHECK_EN is defined).
module truth_table_checker #(
  parameter int                  N_IN   = 3,
  parameter logic [2**N_IN-1:0]  TRUTH  = {2**N_IN{1'b0}},
  parameter int                  SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            sop_in,
  input  logic            kmap_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err,
  output logic            first_err_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(2**N_IN - 1);
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(2**N_IN);
  localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic [N_IN-1:0] vec_d, first_err_d;
  logic [N_IN:0]   err_d;
  logic            fev_d, pass_d, row_fail;

`ifdef TT_KMAP_CHECK_EN
  assign row_fail = (sop_in != TRUTH[vec]) || (kmap_in != TRUTH[vec]);
`else
  logic unused_kmap;
  assign unused_kmap = kmap_in;
  assign row_fail    = (sop_in != TRUTH[vec]);
`endif

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    vec_d       = vec;
    err_d       = err_count;
    first_err_d = first_err;
    fev_d       = first_err_valid;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_SETTLE;
          cnt_d       = '0;
          vec_d       = '0;
          err_d       = '0;
          first_err_d = '0;
          fev_d       = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_LAST) state_d = ST_CHECK;
        else                 cnt_d   = cnt + 1'b1;
      end
      ST_CHECK: begin
        if (row_fail) begin
          if (err_count != ERR_MAX) err_d = err_count + 1'b1;
          if (!first_err_valid) begin
            first_err_d = vec;
            fev_d       = 1'b1;
          end
        end
        if (vec == VEC_LAST) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec + 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pass_d = (state_d == ST_DONE) && (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      vec             <= '0;
      err_count       <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      vec             <= vec_d;
      err_count       <= err_d;
      first_err       <= first_err_d;
      first_err_valid <= fev_d;
      pass            <= pass_d;
    end
  end

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: majority function, directed fault rows plus random
// fault masks, checked against a popcount / lowest-set-bit reference model.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] starts = 2'b00;
  logic [7:0] smask = 8'h00;
  logic [7:0] kmask = 8'h00;
  int         sel = 0;
  int         checks = 0;
  int         errors = 0;

  logic [2:0] vec0, vec1, fe0, fe1;
  logic [3:0] ec0, ec1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fev0, fev1;
  logic       sop0, sop1, km0, km1;

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return $countones(v) >= 2;
  endfunction

  always_comb begin
    sop0 = maj(vec0) ^ smask[vec0];
    km0  = maj(vec0) ^ kmask[vec0];
    sop1 = maj(vec1) ^ smask[vec1];
    km1  = maj(vec1) ^ kmask[vec1];
  end

  truth_table_checker #(.N_IN(3), .TRUTH(8'hE8), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(starts[0]), .vec(vec0), .sop_in(sop0), .kmap_in(km0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .first_err(fe0),
    .first_err_valid(fev0));

  truth_table_checker #(.N_IN(3), .TRUTH(8'hE8), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(starts[1]), .vec(vec1), .sop_in(sop1), .kmap_in(km1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .first_err(fe1),
    .first_err_valid(fev1));

  logic [2:0] d_vec, d_fe;
  logic [3:0] d_ec;
  logic       d_busy, d_done, d_pass, d_fev;
  always_comb begin
    d_vec  = (sel == 1) ? vec1  : vec0;
    d_fe   = (sel == 1) ? fe1   : fe0;
    d_ec   = (sel == 1) ? ec1   : ec0;
    d_busy = (sel == 1) ? busy1 : busy0;
    d_done = (sel == 1) ? done1 : done0;
    d_pass = (sel == 1) ? pass1 : pass0;
    d_fev  = (sel == 1) ? fev1  : fev0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " vec"}, 32'(d_vec), 0);
    chk({tag, " busy"}, 32'(d_busy), 0);
    chk({tag, " done"}, 32'(d_done), 0);
    chk({tag, " pass"}, 32'(d_pass), 0);
    chk({tag, " err_count"}, 32'(d_ec), 0);
    chk({tag, " first_err"}, 32'(d_fe), 0);
    chk({tag, " first_err_valid"}, 32'(d_fev), 0);
  endtask

  // One full sweep on DUT `which` with the given fault masks; everything expected comes
  // from the masks: failing rows = set bits of the effective mask.
  task automatic sweep(input int which, input int settle, input logic [7:0] sm,
                       input logic [7:0] km, input bit hold);
    logic [7:0] eff;
    int exp_err, exp_first, j;
    eff = sm;
`ifdef TT_KMAP_CHECK_EN
    eff = sm | km;
`endif
    exp_err = $countones(eff);
    exp_first = 0;
    for (int i = 7; i >= 0; i--) if (eff[i]) exp_first = i;

    @(negedge clk);
    sel = which;
    smask = sm;
    kmask = km;
    starts[which] = 1'b1;
    @(posedge clk); #1;
    chk("start busy", 32'(d_busy), 1);
    chk("start done", 32'(d_done), 0);
    chk("start err_count cleared", 32'(d_ec), 0);
    chk("start first_err_valid cleared", 32'(d_fev), 0);
    if (!hold) starts[which] = 1'b0;
    j = 0;
    while (!d_done && j < 400) begin
      chk("row vec", 32'(d_vec), 32'(j / (settle + 1)));
      @(posedge clk); #1;
      j++;
    end
    starts[which] = 1'b0;
    chk("done latency", 32'(j), 32'(8 * (settle + 1)));
    chk("done busy", 32'(d_busy), 0);
    chk("done vec held", 32'(d_vec), 7);
    chk("err_count", 32'(d_ec), 32'(exp_err));
    chk("first_err_valid", 32'(d_fev), 32'(exp_err != 0));
    chk("first_err", 32'(d_fe), 32'(exp_first));
    chk("pass", 32'(d_pass), 32'(exp_err == 0));
    repeat (2) @(posedge clk);
    #1;
    chk("done stable", 32'(d_done), 1);
    chk("err_count stable", 32'(d_ec), 32'(exp_err));
  endtask

  initial begin
    logic [7:0] stuck0;
    int k;
    for (int v = 0; v < 8; v++) stuck0[v] = maj(3'(v));

    #12;
    sel = 0;
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    sweep(0, 1, 8'h00, 8'h00, 0);           // clean majority
    sweep(0, 1, 8'h20, 8'h00, 0);           // sop wrong at vec 5
    sweep(0, 1, stuck0, 8'h00, 0);          // sop stuck at 0
    sweep(0, 1, 8'h00, 8'h40, 0);           // kmap wrong at vec 6
    sweep(0, 1, 8'h00, 8'h00, 1);           // start held through sweep
    sweep(0, 1, 8'hFF, 8'hFF, 0);           // every row wrong
    sweep(0, 1, 8'h00, 8'h00, 0);           // restart from DONE clears results

    // reset mid-sweep at vec 4
    @(negedge clk);
    smask = 8'h01;
    starts[0] = 1'b1;
    @(negedge clk);
    starts[0] = 1'b0;
    k = 0;
    while (vec0 != 3'd4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach vec 4", 32'(k < 100), 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid-sweep reset");
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, 1, 8'h00, 8'h00, 0);

    for (int r = 0; r < 6; r++)
      sweep(0, 1, 8'($urandom), 8'($urandom), 0);

    sweep(1, 3, 8'h00, 8'h00, 0);
    sweep(1, 3, 8'($urandom), 8'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
